// File: rtl/bcd_7seg_scan_driver.sv
// Time-multiplexed 4-digit 7-segment driver with per-frame snapshot,
// leading-zero blanking, dash display for non-BCD nibbles and ghost guard.
module bcd_7seg_scan_driver #(
    parameter int unsigned REFRESH_DIV    = 25000,
    parameter int unsigned SEG_ACTIVE_LOW = 0,
    parameter int unsigned DIG_ACTIVE_LOW = 0,
    parameter int unsigned BLANK_LEADING  = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] units,
    input  logic [3:0] tens,
    input  logic [3:0] hundreds,
    input  logic [3:0] thousands,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] digit_sel,
    output logic       frame_tick
);

    localparam int unsigned     PW         = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [6:0]      SEG_INV    = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic            DP_INV     = (SEG_ACTIVE_LOW != 0);
    localparam logic [3:0]      DIG_INV    = (DIG_ACTIVE_LOW != 0) ? 4'hF : 4'h0;

    logic [PW-1:0] presc;
    logic [1:0]    idx;
    logic [15:0]   snapshot;

    logic          slot_end_c;
    logic          frame_end_c;
    logic [3:0]    nibble_c;
    logic [3:0]    lead_zero_c;
    logic          blank_c;
    logic [6:0]    pattern_c;
    logic [6:0]    seg_next_c;

    assign slot_end_c  = (presc == PRESC_LAST);
    assign frame_end_c = slot_end_c && (idx == 2'd3);

    // Digit select, leading-zero chain and segment decode for the current slot
    always_comb begin
        nibble_c       = 4'h0;
        lead_zero_c    = 4'b0000;
        blank_c        = 1'b0;
        pattern_c      = 7'h00;
        seg_next_c     = 7'h00;

        case (idx)
            2'd0:    nibble_c = snapshot[3:0];
            2'd1:    nibble_c = snapshot[7:4];
            2'd2:    nibble_c = snapshot[11:8];
            default: nibble_c = snapshot[15:12];
        endcase

        // A digit is a leading zero only if it and everything left of it is zero
        lead_zero_c[3] = (snapshot[15:12] == 4'h0);
        lead_zero_c[2] = lead_zero_c[3] && (snapshot[11:8] == 4'h0);
        lead_zero_c[1] = lead_zero_c[2] && (snapshot[7:4] == 4'h0);
        lead_zero_c[0] = 1'b0;
        blank_c        = (BLANK_LEADING != 0) && lead_zero_c[idx];

        case (nibble_c)
            4'h0:    pattern_c = 7'h3F;
            4'h1:    pattern_c = 7'h06;
            4'h2:    pattern_c = 7'h5B;
            4'h3:    pattern_c = 7'h4F;
            4'h4:    pattern_c = 7'h66;
            4'h5:    pattern_c = 7'h6D;
            4'h6:    pattern_c = 7'h7D;
            4'h7:    pattern_c = 7'h07;
            4'h8:    pattern_c = 7'h7F;
            4'h9:    pattern_c = 7'h6F;
            default: pattern_c = 7'h40;
        endcase

        seg_next_c = blank_c ? 7'h00 : pattern_c;
    end

    // Scan timing, frame snapshot and registered pin outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            presc      <= '0;
            idx        <= 2'd0;
            snapshot   <= 16'h0000;
            frame_tick <= 1'b0;
            seg        <= SEG_INV;
            dp         <= DP_INV;
            digit_sel  <= DIG_INV;
        end else begin
            presc      <= slot_end_c ? '0 : presc + PW'(1);
            frame_tick <= frame_end_c;
            dp         <= DP_INV;
            if (slot_end_c) begin
                idx <= idx + 2'd1;
            end
            if (frame_end_c) begin
                snapshot <= {thousands, hundreds, tens, units};
            end
            if (!enable) begin
                seg       <= SEG_INV;
                digit_sel <= DIG_INV;
            end else begin
                seg       <= seg_next_c ^ SEG_INV;
                // Blank the digit enable for one cycle across a slot change
                digit_sel <= slot_end_c ? DIG_INV : ((4'b0001 << idx) ^ DIG_INV);
            end
        end
    end

endmodule

// File: tb/tb_bcd_7seg_scan_driver.sv
// Randomized bench for bcd_7seg_scan_driver: a cycle-count reference model
// drives expectations for an active-high and an active-low instance.
module tb_bcd_7seg_scan_driver;

    localparam int unsigned DIV   = 4;
    localparam int unsigned FRAME = 4 * DIV;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [3:0] units, tens, hundreds, thousands;

    logic [6:0] seg_a,  seg_b;
    logic       dp_a,   dp_b;
    logic [3:0] dig_a,  dig_b;
    logic       tick_a, tick_b;

    int vectors;
    int miscompares;

    bcd_7seg_scan_driver #(
        .REFRESH_DIV(DIV), .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0), .BLANK_LEADING(1)
    ) dut_a (
        .clk(clk), .reset(reset), .enable(enable),
        .units(units), .tens(tens), .hundreds(hundreds), .thousands(thousands),
        .seg(seg_a), .dp(dp_a), .digit_sel(dig_a), .frame_tick(tick_a)
    );

    bcd_7seg_scan_driver #(
        .REFRESH_DIV(DIV), .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1), .BLANK_LEADING(1)
    ) dut_b (
        .clk(clk), .reset(reset), .enable(enable),
        .units(units), .tens(tens), .hundreds(hundreds), .thousands(thousands),
        .seg(seg_b), .dp(dp_b), .digit_sel(dig_b), .frame_tick(tick_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: everything derives from the count of edges since reset
    logic [6:0]  font [16];
    int unsigned n;
    logic [15:0] m_snap;
    logic [6:0]  exp_seg;
    logic [3:0]  exp_dig;
    logic        exp_tick;
    int unsigned ph, ix;
    bit          zero_run;

    initial begin
        font[0]  = 7'h3F; font[1]  = 7'h06; font[2]  = 7'h5B; font[3]  = 7'h4F;
        font[4]  = 7'h66; font[5]  = 7'h6D; font[6]  = 7'h7D; font[7]  = 7'h07;
        font[8]  = 7'h7F; font[9]  = 7'h6F;
        for (int k = 10; k < 16; k++) font[k] = 7'h40;
    end

    always @(posedge clk) begin
        if (reset) begin
            n        <= 0;
            m_snap   <= 16'h0000;
            exp_seg  <= 7'h00;
            exp_dig  <= 4'h0;
            exp_tick <= 1'b0;
        end else begin
            ph = n % FRAME;
            ix = ph / DIV;
            zero_run = (ix != 0);
            for (int j = 3; j >= 0; j--) begin
                if (j >= int'(ix) && m_snap[4*j +: 4] != 4'h0) zero_run = 0;
            end
            exp_tick <= (ph == FRAME - 1);
            if (ph == FRAME - 1) m_snap <= {thousands, hundreds, tens, units};
            exp_seg <= !enable ? 7'h00 : (zero_run ? 7'h00 : font[m_snap[4*ix +: 4]]);
            exp_dig <= (!enable || (n % DIV) == DIV - 1) ? 4'h0 : 4'(1 << ix);
            n <= n + 1;
        end
    end

    task automatic check_outputs();
        vectors++;
        assert (seg_a === exp_seg) else begin
            miscompares++; $error("FAIL seg_a got %h expected %h at n=%0d", seg_a, exp_seg, n);
        end
        vectors++;
        assert (dig_a === exp_dig) else begin
            miscompares++; $error("FAIL digit_sel_a got %b expected %b at n=%0d", dig_a, exp_dig, n);
        end
        vectors++;
        assert (dp_a === 1'b0) else begin
            miscompares++; $error("FAIL dp_a got %b expected 0", dp_a);
        end
        vectors++;
        assert (tick_a === exp_tick) else begin
            miscompares++; $error("FAIL frame_tick_a got %b expected %b at n=%0d", tick_a, exp_tick, n);
        end
        vectors++;
        assert (seg_b === ~exp_seg) else begin
            miscompares++; $error("FAIL seg_b got %h expected %h at n=%0d", seg_b, ~exp_seg, n);
        end
        vectors++;
        assert (dig_b === ~exp_dig) else begin
            miscompares++; $error("FAIL digit_sel_b got %b expected %b at n=%0d", dig_b, ~exp_dig, n);
        end
        vectors++;
        assert (dp_b === 1'b1) else begin
            miscompares++; $error("FAIL dp_b got %b expected 1", dp_b);
        end
        vectors++;
        assert (tick_b === exp_tick) else begin
            miscompares++; $error("FAIL frame_tick_b got %b expected %b at n=%0d", tick_b, exp_tick, n);
        end
    endtask

    task automatic cycles(input int count);
        for (int c = 0; c < count; c++) begin
            @(negedge clk);
            check_outputs();
        end
    endtask

    task automatic set_digits(input logic [3:0] th, input logic [3:0] h,
                              input logic [3:0] t, input logic [3:0] u);
        thousands = th; hundreds = h; tens = t; units = u;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset  = 1'b1;
        enable = 1'b0;
        set_digits(4'h0, 4'h0, 4'h0, 4'h0);
        cycles(3);

        // Counting display 4321; first frame still shows the cleared snapshot
        reset  = 1'b0;
        enable = 1'b1;
        set_digits(4'h4, 4'h3, 4'h2, 4'h1);
        @(negedge clk);
        check_outputs();
        vectors++;
        assert (seg_a === 7'h3F && dig_a === 4'b0001) else begin
            miscompares++; $error("FAIL first_digit got %h/%b expected 3f/0001", seg_a, dig_a);
        end
        cycles(2 * FRAME + 5);

        set_digits(4'h0, 4'h0, 4'h5, 4'h0);
        cycles(2 * FRAME);
        set_digits(4'h0, 4'hC, 4'h0, 4'h7);
        cycles(2 * FRAME);

        // Mid-frame input changes must stay invisible until the next snapshot
        for (int r = 0; r < 20; r++) begin
            set_digits(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                       4'($urandom_range(0, 15)), 4'($urandom_range(0, 9)));
            if ($urandom_range(0, 2) == 0) thousands = 4'h0;
            if ($urandom_range(0, 3) == 0) hundreds  = 4'h0;
            cycles(int'($urandom_range(1, 9)));
        end

        enable = 1'b0;
        cycles(10);
        enable = 1'b1;
        cycles(FRAME + 3);

        // Random enable, inputs and mid-slot resets
        for (int r = 0; r < 300; r++) begin
            reset  = ($urandom_range(0, 24) == 0);
            enable = ($urandom_range(0, 6) != 0);
            if ($urandom_range(0, 3) == 0) begin
                set_digits(4'($urandom_range(0, 2) == 0 ? 0 : $urandom_range(0, 15)),
                           4'($urandom_range(0, 2) == 0 ? 0 : $urandom_range(0, 15)),
                           4'($urandom_range(0, 2) == 0 ? 0 : $urandom_range(0, 15)),
                           4'($urandom_range(0, 15)));
            end
            cycles(1);
        end

        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
        cycles(FRAME + 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
